memory_reader: RTL and testbench

Read-side counterpart of `memory_writer`. It accepts a completed frame (`frame_ready` plus `base_addr_in`) and fetches the frame from memory as a series of INCR bursts through the read control port of `AXI_memory_master_burst`. Returned beats are buffered in an internal FIFO and re-emitted as an AXI-stream master, with `tuser` marking the start of frame and `tlast` marking the end of each line. It sits between the frame buffer memory and downstream video processing.

---
 rtl/memory_reader.sv | 205 ++++++++++++++++++++
 tb/tb_memory_reader.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// memory_reader
// Fetches a completed frame from memory as a series of INCR read bursts, with at most
// one burst outstanding. Returned beats go into a beat FIFO and are replayed as an
// AXI-stream master. tuser marks the first pixel of a frame; tlast marks the last pixel
// of each line.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   frame_ready, base_addr_in         frame request (sampled only while idle)
//   pixels_per_frame, frame_width     frame geometry, latched when the frame is accepted
//   start_read, read_addr, read_len   one-cycle burst request (len = beats - 1)
//   read_size, read_burst             constant beat size / INCR burst type
//   rd_data, rd_valid, rd_last        returned read beats (no backpressure)
//   m_axis_tdata/tvalid/tready        pixel stream
//   m_axis_tlast, m_axis_tuser        end of line / start of frame
//   busy, frame_done                  frame in progress / completion pulse
module memory_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_ready,
    input  logic [ADDR_WIDTH-1:0] base_addr_in,
    input  logic [31:0]           pixels_per_frame,
    input  logic [15:0]           frame_width,
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_len,
    output logic [2:0]            read_size,
    output logic [1:0]            read_burst,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_valid,
    input  logic                  rd_last,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned BytesPerBeat = DATA_WIDTH / 8;
    localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW         = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSpace,
        StIssue,
        StWaitData,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           remaining_q;
    logic [31:0]           ppf_q;
    logic [15:0]           width_q;
    logic [31:0]           pix_cnt_q;
    logic [15:0]           col_cnt_q;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  burst_done;
    logic                  fifo_empty;
    logic                  last_col;
    logic                  frame_complete;
    logic [31:0]           beats;
    logic [31:0]           free_entries;
    logic [ADDR_WIDTH-1:0] addr_step;

    // A zero-length frame request is dropped so the FSM never waits on an empty frame.
    assign accept         = (state_q == StIdle) && frame_ready && (pixels_per_frame != 32'd0);
    assign beats          = (remaining_q < 32'(BURST_LEN)) ? remaining_q : 32'(BURST_LEN);
    assign free_entries   = 32'(FIFO_DEPTH) - 32'(count_q);
    // Beats outside WAIT_DATA are strays and never reach the FIFO.
    assign push           = (state_q == StWaitData) && rd_valid;
    assign burst_done     = push && rd_last;
    assign fifo_empty     = (count_q == '0);
    assign pop            = !fifo_empty && m_axis_tready;
    // With frame_width = 0 this compares against 16'hFFFF, so the column counter simply
    // wraps through the full range.
    assign last_col       = (col_cnt_q == frame_width_m1(width_q));
    assign frame_complete = (pix_cnt_q == ppf_q);
    assign addr_step      = ADDR_WIDTH'(beats * 32'(BytesPerBeat));

    function automatic logic [15:0] frame_width_m1(input logic [15:0] w);
        return w - 16'd1;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StWaitSpace;
            end
            // Only request a burst once the FIFO can absorb all of it, so the FIFO can
            // never overflow even with the stream stalled.
            StWaitSpace: begin
                if (free_entries >= beats) state_d = StIssue;
            end
            StIssue: begin
                state_d = StWaitData;
            end
            StWaitData: begin
                if (burst_done) state_d = (remaining_q == beats) ? StDrain : StWaitSpace;
            end
            StDrain: begin
                if (frame_complete) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_read = (state_q == StIssue);
        read_addr  = start_read ? addr_q : '0;
        read_len   = start_read ? (beats - 32'd1) : 32'd0;
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDrain) && frame_complete;
    end

    assign read_size  = 3'($clog2(BytesPerBeat));
    assign read_burst = 2'b01;

    // ---------------------------------------------------------------- frame datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            ppf_q       <= '0;
            width_q     <= '0;
        end else if (accept) begin
            addr_q      <= base_addr_in;
            remaining_q <= pixels_per_frame;
            ppf_q       <= pixels_per_frame;
            width_q     <= frame_width;
        end else if (burst_done) begin
            addr_q      <= addr_q + addr_step;
            remaining_q <= remaining_q - beats;
        end
    end

    // Pixel and column counters advance on every stream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
            col_cnt_q <= '0;
        end else if (accept) begin
            pix_cnt_q <= '0;
            col_cnt_q <= '0;
        end else if (pop) begin
            pix_cnt_q <= pix_cnt_q + 32'd1;
            col_cnt_q <= last_col ? 16'd0 : col_cnt_q + 16'd1;
        end
    end

    // ---------------------------------------------------------------- beat FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rd_data;
    end

    // ---------------------------------------------------------------- stream outputs
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (width_q != 16'd0) && last_col;
    assign m_axis_tuser  = m_axis_tvalid && (pix_cnt_q == 32'd0);

endmodule

// File: tb/tb_memory_reader.sv
module tb_memory_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_ready = 1'b0;
    logic [31:0] base_addr_in = '0;
    logic [31:0] pixels_per_frame = '0;
    logic [15:0] frame_width = '0;
    logic        start_read;
    logic [31:0] read_addr;
    logic [31:0] read_len;
    logic [2:0]  read_size;
    logic [1:0]  read_burst;
    logic [31:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        rd_last = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    memory_reader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .BURST_LEN (16),
        .FIFO_DEPTH(32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_ready     (frame_ready),
        .base_addr_in    (base_addr_in),
        .pixels_per_frame(pixels_per_frame),
        .frame_width     (frame_width),
        .start_read      (start_read),
        .read_addr       (read_addr),
        .read_len        (read_len),
        .read_size       (read_size),
        .read_burst      (read_burst),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_last         (rd_last),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    typedef struct {
        logic [31:0] data;
        bit          last;
        bit          user;
        bit          eof;
    } pixel_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    int errors = 0;
    int checks = 0;

    // Reference model state
    pixel_t      exp_pix[$];
    burst_t      exp_burst[$];
    bit          mbusy = 0;
    bit          done_pending = 0;
    int          issue_cd = 0;
    int          n_start = 0;
    int          n_done = 0;
    int          n_accept = 0;

    // Logs of what the DUT actually produced, for the literal checks
    logic [31:0] log_data[$];
    bit          log_last[$];
    bit          log_user[$];
    burst_t      log_burst[$];

    // Memory contents and environment knobs
    logic [31:0] data_origin = '0;
    logic [31:0] data_offset = '0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    int          stray_pct = 0;
    bit          ready_manual = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return ((addr - data_origin) >> 2) + 32'd1 + data_offset;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // What a frame must look like, straight from the frame geometry.
    task automatic model_frame(input logic [31:0] base, input logic [31:0] ppf,
                               input logic [15:0] w);
        logic [31:0] rem;
        logic [31:0] a;
        logic [31:0] n;
        for (int i = 0; i < int'(ppf); i++) begin
            pixel_t p;
            p.data = mem_word(base + 32'(i) * 32'd4);
            p.last = (w != 0) && ((i % int'(w)) == int'(w) - 1);
            p.user = (i == 0);
            p.eof  = (i == int'(ppf) - 1);
            exp_pix.push_back(p);
        end
        rem = ppf;
        a   = base;
        while (rem > 0) begin
            n = (rem < 32'd16) ? rem : 32'd16;
            exp_burst.push_back('{addr: a, len: n - 32'd1});
            a   = a + n * 32'd4;
            rem = rem - n;
        end
    endtask

    // Compare process: everything sampled at the falling edge.
    initial begin
        pixel_t      p;
        burst_t      b;
        bit          has;
        bit          clr;
        bit          prev_stall;
        logic [31:0] prev_data;
        bit          prev_last;
        bit          prev_user;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 0;
        prev_user  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            check("busy", busy, mbusy);
            check("frame_done", frame_done, done_pending);
            if (frame_done) n_done++;
            clr = done_pending;
            done_pending = 0;
            if (issue_cd > 0) begin
                issue_cd--;
                if (issue_cd == 0) check("issue_latency", start_read, 1);
            end
            if (start_read) begin
                n_start++;
                log_burst.push_back('{addr: read_addr, len: read_len});
                has = (exp_burst.size() != 0);
                check("burst_expected", has, 1);
                if (has) begin
                    b = exp_burst.pop_front();
                    check("read_addr", read_addr, b.addr);
                    check("read_len", read_len, b.len);
                    check("read_size", read_size, 3'd2);
                    check("read_burst", read_burst, 2'b01);
                end
            end
            if (prev_stall) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_tdata", m_axis_tdata, prev_data);
                check("hold_tlast", m_axis_tlast, prev_last);
                check("hold_tuser", m_axis_tuser, prev_user);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                log_data.push_back(m_axis_tdata);
                log_last.push_back(m_axis_tlast);
                log_user.push_back(m_axis_tuser);
                has = (exp_pix.size() != 0);
                check("pixel_expected", has, 1);
                if (has) begin
                    p = exp_pix.pop_front();
                    check("tdata", m_axis_tdata, p.data);
                    check("tlast", m_axis_tlast, p.last);
                    check("tuser", m_axis_tuser, p.user);
                    done_pending = p.eof;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_user  = m_axis_tuser;
            if (!mbusy && frame_ready && pixels_per_frame != 32'd0) begin
                mbusy = 1;
                n_accept++;
                issue_cd = 2;
                model_frame(base_addr_in, pixels_per_frame, frame_width);
            end
            if (clr) mbusy = 0;
        end
    end

    // Memory side: answers each burst request, with random gaps and stray beats.
    initial begin
        bit          active;
        logic [31:0] out_addr;
        int          out_left;
        active   = 0;
        out_addr = '0;
        out_left = 0;
        forever begin
            @(posedge clk);
            #1;
            rd_valid = 0;
            rd_last  = 0;
            rd_data  = '0;
            if (!rst_n) begin
                active = 0;
            end else if (active) begin
                if ($urandom_range(99) < valid_pct) begin
                    rd_valid = 1;
                    rd_data  = mem_word(out_addr);
                    rd_last  = (out_left == 1);
                    out_addr = out_addr + 32'd4;
                    out_left--;
                    if (out_left == 0) active = 0;
                end
            end else if (start_read) begin
                active   = 1;
                out_addr = read_addr;
                out_left = int'(read_len) + 1;
            end else if ($urandom_range(99) < stray_pct) begin
                rd_valid = 1;
                rd_data  = 32'hDEAD_0000 | $urandom_range(16'hFFFF);
                rd_last  = 1'($urandom_range(1));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!ready_manual) m_axis_tready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [31:0] base, input logic [31:0] ppf,
                               input logic [15:0] w);
        @(posedge clk);
        #1;
        frame_ready      = 1;
        base_addr_in     = base;
        pixels_per_frame = ppf;
        frame_width      = w;
        @(posedge clk);
        #1;
        frame_ready      = 0;
        // Inputs must have been latched; scramble them.
        base_addr_in     = $urandom;
        pixels_per_frame = $urandom_range(200);
        frame_width      = 16'($urandom_range(20));
    endtask

    task automatic flush_model();
        exp_pix.delete();
        exp_burst.delete();
        mbusy        = 0;
        done_pending = 0;
        issue_cd     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_read"}, start_read, 0);
        check({tag, "_read_addr"}, read_addr, 0);
        check({tag, "_read_len"}, read_len, 0);
        check({tag, "_read_size"}, read_size, 3'd2);
        check({tag, "_read_burst"}, read_burst, 2'b01);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tdata"}, m_axis_tdata, 0);
        check({tag, "_tlast"}, m_axis_tlast, 0);
        check({tag, "_tuser"}, m_axis_tuser, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (mbusy && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_timeout"}, mbusy, 0);
        if (mbusy) begin
            @(posedge clk);
            #2;
            rst_n = 0;
            #1;
            flush_model();
            @(posedge clk);
            #2;
            rst_n = 1;
        end
        check({name, "_bursts_left"}, 32'(exp_burst.size()), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        log_user.delete();
        log_burst.delete();
    endtask

    initial begin
        int s0;
        int d0;
        int a0;
        int n;
        int users;

        // ---- reset
        #2 rst_n = 0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        repeat (2) @(posedge clk);

        // ---- single-burst frame: memory holds 1..8 at 0x100
        data_origin = 32'h100;
        data_offset = 0;
        valid_pct = 100; ready_pct = 100; stray_pct = 0;
        clear_logs();
        d0 = n_done;
        start_frame(32'h100, 8, 4);
        wait_idle("single", 200);
        check("single_nbursts", 32'(log_burst.size()), 1);
        if (log_burst.size() >= 1) begin
            check("single_addr", log_burst[0].addr, 32'h100);
            check("single_len", log_burst[0].len, 7);
        end
        check("single_npix", 32'(log_data.size()), 8);
        if (log_data.size() == 8) begin
            for (int i = 0; i < 8; i++) check("single_data", log_data[i], 32'(i + 1));
            check("single_tlast", {log_last[0], log_last[1], log_last[2], log_last[3],
                                   log_last[4], log_last[5], log_last[6], log_last[7]},
                  8'b0001_0001);
            check("single_tuser", {log_user[0], log_user[1], log_user[2], log_user[3],
                                   log_user[4], log_user[5], log_user[6], log_user[7]},
                  8'b1000_0000);
        end
        check("single_done", 32'(n_done - d0), 1);

        // ---- multi-burst frame
        data_origin = 0;
        valid_pct = 70; ready_pct = 80;
        clear_logs();
        start_frame(32'h0, 40, 8);
        wait_idle("multi", 1000);
        check("multi_nbursts", 32'(log_burst.size()), 3);
        if (log_burst.size() == 3) begin
            check("multi_b0", {log_burst[0].addr, log_burst[0].len}, {32'h00, 32'd15});
            check("multi_b1", {log_burst[1].addr, log_burst[1].len}, {32'h40, 32'd15});
            check("multi_b2", {log_burst[2].addr, log_burst[2].len}, {32'h80, 32'd7});
        end
        check("multi_npix", 32'(log_data.size()), 40);
        if (log_data.size() == 40) check("multi_last_data", log_data[39], 40);

        // ---- backpressure: FIFO full, third burst only after 16 pops
        valid_pct = 100;
        @(posedge clk);
        #1;
        ready_manual = 1;
        m_axis_tready = 0;
        data_offset = 32'h1000;
        s0 = n_start;
        start_frame(32'h2000, 64, 16);
        repeat (120) @(posedge clk);
        check("bp_two_bursts", 32'(n_start - s0), 2);
        #1 m_axis_tready = 1;
        repeat (15) @(posedge clk);
        #1 m_axis_tready = 0;
        repeat (50) @(posedge clk);
        check("bp_15_pops", 32'(n_start - s0), 2);
        #1 m_axis_tready = 1;
        @(posedge clk);
        #1 m_axis_tready = 0;
        repeat (10) @(posedge clk);
        check("bp_16_pops", 32'(n_start - s0), 3);
        #1 ready_manual = 0;
        ready_pct = 100;
        wait_idle("bp", 1000);

        // ---- frame_ready while busy, then a zero-length frame
        valid_pct = 60; ready_pct = 70; stray_pct = 10;
        s0 = n_start;
        start_frame(32'h300, 30, 5);
        repeat (10) @(posedge clk);
        start_frame(32'h0099_9000, 50, 3);
        wait_idle("busy", 1000);
        check("busy_nbursts", 32'(n_start - s0), 2);
        s0 = n_start;
        start_frame(32'h400, 0, 4);
        repeat (10) @(posedge clk);
        check("zero_busy", busy, 0);
        check("zero_nbursts", 32'(n_start - s0), 0);

        // ---- reset during WAIT_DATA
        valid_pct = 50;
        s0 = n_start;
        start_frame(32'h500, 48, 6);
        n = 0;
        while (n_start == s0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("rst_saw_issue", 32'(n_start - s0), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1 check_reset_outputs("midrst");
        flush_model();
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        data_offset = 32'h5000;
        clear_logs();
        start_frame(32'h600, 12, 4);
        wait_idle("after_rst", 1000);
        check("after_rst_npix", 32'(log_user.size()), 12);
        if (log_user.size() >= 1) check("after_rst_tuser", log_user[0], 1);

        // ---- back-to-back frames with frame_ready held high
        valid_pct = 100; ready_pct = 100; stray_pct = 0;
        clear_logs();
        d0 = n_done;
        a0 = n_accept;
        @(posedge clk);
        #1;
        frame_ready = 1;
        base_addr_in = 32'h700;
        pixels_per_frame = 8;
        frame_width = 4;
        n = 0;
        while (n_accept < a0 + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_accepts", 32'(n_accept - a0), 4);
        @(posedge clk);
        #1 frame_ready = 0;
        wait_idle("b2b", 400);
        check("b2b_done", 32'(n_done - d0), 4);
        users = 0;
        foreach (log_user[i]) users += int'(log_user[i]);
        check("b2b_tuser_count", 32'(users), 4);
        if (log_user.size() == 32) check("b2b_tuser_pos", {log_user[0], log_user[8],
                                          log_user[16], log_user[24]}, 4'hF);

        // ---- randomized frames
        stray_pct = 10;
        for (int f = 0; f < 25; f++) begin
            logic [31:0] base;
            valid_pct   = 30 + $urandom_range(70);
            ready_pct   = 30 + $urandom_range(70);
            data_offset = $urandom;
            base = (f % 4 == 3) ? (32'hFFFF_FF00 + 32'($urandom_range(63)) * 4)
                                : ($urandom & 32'hFFFF_FFFC);
            start_frame(base, 32'($urandom_range(1, 70)), 16'($urandom_range(9)));
            if (f % 3 == 0) begin
                repeat ($urandom_range(20)) @(posedge clk);
                start_frame($urandom, 32'($urandom_range(1, 30)), 16'd3);
            end
            wait_idle("rand", 3000);
        end

        check("final_pixels_left", 32'(exp_pix.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
